// File: rtl/pair_pack_if.sv
// Handshake bundle between the two byte requesters, the pair packer and the
// downstream pair consumer.
interface pair_pack_if;
  logic       req0_valid;
  logic [7:0] req0_byte;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_byte;
  logic       req1_ready;
  logic       cfg_sum;
  logic       out_valid;
  logic       out_ready;
  logic [15:0] out_pair;
  logic       out_src;

  // Scheduler side.
  modport slave (
    input  req0_valid, req0_byte, req1_valid, req1_byte, cfg_sum, out_ready,
    output req0_ready, req1_ready, out_valid, out_pair, out_src
  );

  // Requester / consumer side.
  modport master (
    output req0_valid, req0_byte, req1_valid, req1_byte, cfg_sum, out_ready,
    input  req0_ready, req1_ready, out_valid, out_pair, out_src
  );
endinterface

// File: rtl/pair_pack_sched.sv
// Round-robin scheduler that packs two bytes from one requester into a 16-bit
// pair, holds it on a valid/ready output, and drops pairs stalled too long.
module pair_pack_sched #(
  parameter int unsigned TIMEOUT_CYC = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  pair_pack_if.slave       bus,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
);

  localparam int unsigned TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE1 = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic             prio, prio_d;
  logic             gnt, gnt_d;
  logic [TMO_W-1:0] tmo, tmo_d;
  logic [7:0]       b0, b0_d;
  logic             out_valid_d;
  logic [15:0]      out_pair_d;
  logic             out_src_d;
  logic [CNT_W-1:0] drop_d;

  logic       grant;
  logic       sel_valid;
  logic [7:0] sel_byte;
  logic       rdy0, rdy1;

  // Next-state, datapath updates and requester readies.
  always_comb begin
    state_d     = state;
    prio_d      = prio;
    gnt_d       = gnt;
    tmo_d       = tmo;
    b0_d        = b0;
    out_valid_d = bus.out_valid;
    out_pair_d  = bus.out_pair;
    out_src_d   = bus.out_src;
    drop_d      = drop_cnt;
    rdy0        = 1'b0;
    rdy1        = 1'b0;
    grant       = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;
    sel_valid   = gnt ? bus.req1_valid : bus.req0_valid;
    sel_byte    = gnt ? bus.req1_byte  : bus.req0_byte;

    unique case (state)
      IDLE: begin
        if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
          rdy0    = ~grant;
          rdy1    = grant;
          b0_d    = grant ? bus.req1_byte : bus.req0_byte;
          gnt_d   = grant;
          tmo_d   = '0;
          state_d = BYTE1;
        end
      end

      BYTE1: begin
        rdy0 = rst_n && !gnt && bus.req0_valid;
        rdy1 = rst_n &&  gnt && bus.req1_valid;
        if (sel_valid) begin
          out_pair_d  = {b0, bus.cfg_sum ? 8'(b0 + sel_byte) : sel_byte};
          out_src_d   = gnt;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else if (TIMEOUT_CYC != 0 && tmo == TMO_W'(TMO_LAST)) begin
          // Stalled partial pair: discard first byte and hand priority over.
          if (drop_cnt != {CNT_W{1'b1}}) begin
            drop_d = drop_cnt + CNT_W'(1);
          end
          prio_d  = ~gnt;
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo + TMO_W'(1);
        end
      end

      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          prio_d      = ~gnt;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      prio         <= 1'b0;
      gnt          <= 1'b0;
      tmo          <= '0;
      b0           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_pair <= '0;
      bus.out_src  <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      state        <= state_d;
      prio         <= prio_d;
      gnt          <= gnt_d;
      tmo          <= tmo_d;
      b0           <= b0_d;
      bus.out_valid <= out_valid_d;
      bus.out_pair <= out_pair_d;
      bus.out_src  <= out_src_d;
      drop_cnt     <= drop_d;
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign busy           = (state != IDLE);

endmodule
